// File: rtl/key_cmd_filter.sv
// key_cmd_filter: movement-key sampler, debouncer and strobe generator.
// Keeps only W/A/S/D keycodes and emits press, release and repeat strobes.
module key_cmd_filter #(
    parameter int DEB_FRAMES    = 3,
    parameter int REPEAT_DELAY  = 30,
    parameter int REPEAT_PERIOD = 8
) (
    input  logic       frame_clk,
    input  logic       Reset,
    input  logic [7:0] keycode_in,
    output logic [7:0] keycode,
    output logic       key_valid,
    output logic       press_pulse,
    output logic       release_pulse,
    output logic       repeat_pulse
);

    typedef enum logic [1:0] {
        IDLE,
        DEBOUNCE,
        HELD,
        CHANGING
    } state_t;

    localparam logic [3:0] DEB  = 4'(DEB_FRAMES);
    localparam logic [7:0] RDLY = 8'(REPEAT_DELAY);
    localparam logic [7:0] RPER = 8'(REPEAT_PERIOD);

    state_t     state_q;
    logic [7:0] f_q;
    logic [7:0] cand_q;
    logic [3:0] cnt_q;
    logic [3:0] cnt_d;
    logic [7:0] rcnt_q;
    logic [7:0] rcnt_d;
    logic [7:0] pcnt_q;
    logic [7:0] pcnt_d;
    logic [7:0] key_q;
    logic       press_q;
    logic       release_q;
    logic       repeat_q;
    logic       is_move;

    assign is_move = (keycode_in == 8'h04) || (keycode_in == 8'h07) ||
                     (keycode_in == 8'h16) || (keycode_in == 8'h1A);

    assign cnt_d  = cnt_q + 4'd1;
    assign rcnt_d = (rcnt_q == 8'hFF) ? rcnt_q : rcnt_q + 8'd1;
    assign pcnt_d = pcnt_q + 8'd1;

    assign keycode       = key_q;
    assign key_valid     = (key_q != 8'h00);
    assign press_pulse   = press_q;
    assign release_pulse = release_q;
    assign repeat_pulse  = repeat_q;

    // Register the filtered keycode; non-movement codes read as no key.
    always_ff @(posedge frame_clk or negedge Reset) begin
        if (!Reset) begin
            f_q <= 8'h00;
        end else begin
            f_q <= is_move ? keycode_in : 8'h00;
        end
    end

    // Debounce FSM with registered key and strobe outputs.
    always_ff @(posedge frame_clk or negedge Reset) begin
        if (!Reset) begin
            state_q   <= IDLE;
            cand_q    <= 8'h00;
            cnt_q     <= 4'd0;
            rcnt_q    <= 8'd0;
            pcnt_q    <= 8'd0;
            key_q     <= 8'h00;
            press_q   <= 1'b0;
            release_q <= 1'b0;
            repeat_q  <= 1'b0;
        end else begin
            press_q   <= 1'b0;
            release_q <= 1'b0;
            repeat_q  <= 1'b0;
            unique case (state_q)
                IDLE: begin
                    if (f_q != 8'h00) begin
                        cand_q <= f_q;
                        cnt_q  <= 4'd1;
                        if (DEB == 4'd1) begin
                            key_q   <= f_q;
                            press_q <= 1'b1;
                            rcnt_q  <= 8'd0;
                            pcnt_q  <= 8'd0;
                            state_q <= HELD;
                        end else begin
                            state_q <= DEBOUNCE;
                        end
                    end
                end
                DEBOUNCE: begin
                    if (f_q == 8'h00) begin
                        cnt_q   <= 4'd0;
                        state_q <= IDLE;
                    end else if (f_q == cand_q) begin
                        if (cnt_d >= DEB) begin
                            key_q   <= cand_q;
                            press_q <= 1'b1;
                            rcnt_q  <= 8'd0;
                            pcnt_q  <= 8'd0;
                            state_q <= HELD;
                        end else begin
                            cnt_q <= cnt_d;
                        end
                    end else begin
                        cand_q <= f_q;
                        cnt_q  <= 4'd1;
                    end
                end
                HELD: begin
                    if (f_q == key_q) begin
                        rcnt_q <= rcnt_d;
                        if (RDLY != 8'd0) begin
                            if (rcnt_q < RDLY) begin
                                if (rcnt_d == RDLY) begin
                                    repeat_q <= 1'b1;
                                    pcnt_q   <= 8'd0;
                                end
                            end else if (pcnt_d == RPER) begin
                                repeat_q <= 1'b1;
                                pcnt_q   <= 8'd0;
                            end else begin
                                pcnt_q <= pcnt_d;
                            end
                        end
                    end else begin
                        cand_q <= f_q;
                        cnt_q  <= 4'd1;
                        if (DEB == 4'd1) begin
                            key_q <= f_q;
                            if (f_q == 8'h00) begin
                                release_q <= 1'b1;
                                state_q   <= IDLE;
                            end else begin
                                press_q <= 1'b1;
                                rcnt_q  <= 8'd0;
                                pcnt_q  <= 8'd0;
                            end
                        end else begin
                            state_q <= CHANGING;
                        end
                    end
                end
                CHANGING: begin
                    if (f_q == key_q) begin
                        cnt_q   <= 4'd0;
                        state_q <= HELD;
                    end else if (f_q == cand_q) begin
                        if (cnt_d >= DEB) begin
                            key_q <= cand_q;
                            cnt_q <= 4'd0;
                            if (cand_q == 8'h00) begin
                                release_q <= 1'b1;
                                state_q   <= IDLE;
                            end else begin
                                press_q <= 1'b1;
                                rcnt_q  <= 8'd0;
                                pcnt_q  <= 8'd0;
                                state_q <= HELD;
                            end
                        end else begin
                            cnt_q <= cnt_d;
                        end
                    end else begin
                        cand_q <= f_q;
                        cnt_q  <= 4'd1;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_key_cmd_filter.sv
// tb_key_cmd_filter: scoreboard bench for key_cmd_filter.
// Directed key sequences push expected strobes; a monitor checks them.
module tb_key_cmd_filter;

    logic       frame_clk;
    logic       Reset;
    logic [7:0] keycode_in;
    logic [7:0] keycode;
    logic       key_valid;
    logic       press_pulse;
    logic       release_pulse;
    logic       repeat_pulse;
    logic [7:0] keycode2;
    logic       key_valid2;
    logic       press2;
    logic       release2;
    logic       repeat2;

    key_cmd_filter #(
        .DEB_FRAMES(3),
        .REPEAT_DELAY(30),
        .REPEAT_PERIOD(8)
    ) dut (
        .frame_clk(frame_clk),
        .Reset(Reset),
        .keycode_in(keycode_in),
        .keycode(keycode),
        .key_valid(key_valid),
        .press_pulse(press_pulse),
        .release_pulse(release_pulse),
        .repeat_pulse(repeat_pulse)
    );

    key_cmd_filter #(
        .DEB_FRAMES(3),
        .REPEAT_DELAY(0),
        .REPEAT_PERIOD(8)
    ) dut_norep (
        .frame_clk(frame_clk),
        .Reset(Reset),
        .keycode_in(keycode_in),
        .keycode(keycode2),
        .key_valid(key_valid2),
        .press_pulse(press2),
        .release_pulse(release2),
        .repeat_pulse(repeat2)
    );

    localparam int K_PRESS = 0;
    localparam int K_REL   = 1;
    localparam int K_REP   = 2;

    typedef struct {
        int         cyc;
        int         kind;
        logic [7:0] key;
    } exp_t;

    exp_t sb[$];
    int   tests = 0;
    int   fails = 0;
    int   cyc = 0;
    int   rep2_seen = 0;

    initial frame_clk = 1'b0;
    always #5 frame_clk = ~frame_clk;

    function automatic void push(input int kind, input logic [7:0] key,
                                 input int c);
        exp_t e;
        e.cyc  = c;
        e.kind = kind;
        e.key  = key;
        sb.push_back(e);
    endfunction

    task automatic set_key(input logic [7:0] k, output int e0);
        @(negedge frame_clk);
        keycode_in = k;
        e0 = cyc;
    endtask

    task automatic hold(input int n);
        repeat (n) @(negedge frame_clk);
    endtask

    task automatic chk_key(input string name, input logic [7:0] exp);
        tests++;
        if (keycode !== exp || key_valid !== (exp != 8'h00)) begin
            fails++;
            $display("FAIL %s: keycode=%h valid=%b, want keycode=%h",
                     name, keycode, key_valid, exp);
        end
    endtask

    task automatic chk_idle(input string name);
        tests++;
        if ({keycode, key_valid, press_pulse, release_pulse,
             repeat_pulse} !== 12'h000) begin
            fails++;
            $display("FAIL %s: kc=%h v=%b p=%b r=%b rp=%b, want all 0",
                     name, keycode, key_valid, press_pulse,
                     release_pulse, repeat_pulse);
        end
    endtask

    // Scoreboard monitor: counts edges, then checks strobes just after.
    initial begin
        int   n;
        int   kind;
        exp_t e;
        forever begin
            @(posedge frame_clk);
            cyc++;
            #1;
            if (repeat2) rep2_seen++;
            if (Reset) begin
                tests++;
                if (key_valid !== (keycode != 8'h00)) begin
                    fails++;
                    $display("FAIL key_valid_rel: valid=%b keycode=%h",
                             key_valid, keycode);
                end
                while (sb.size() > 0 && sb[0].cyc < cyc) begin
                    e = sb.pop_front();
                    tests++;
                    fails++;
                    $display("FAIL missed_strobe: kind=%0d key=%h at %0d, not observed",
                             e.kind, e.key, e.cyc);
                end
                n = int'(press_pulse) + int'(release_pulse) +
                    int'(repeat_pulse);
                if (n > 1) begin
                    tests++;
                    fails++;
                    $display("FAIL multi_strobe: %0d strobes at %0d, want <=1",
                             n, cyc);
                end else if (n == 1) begin
                    kind = press_pulse ? K_PRESS :
                           release_pulse ? K_REL : K_REP;
                    tests++;
                    if (sb.size() == 0) begin
                        fails++;
                        $display("FAIL unexpected_strobe: kind=%0d key=%h at %0d, want none",
                                 kind, keycode, cyc);
                    end else begin
                        e = sb.pop_front();
                        if (e.kind != kind || e.key !== keycode ||
                            e.cyc != cyc) begin
                            fails++;
                            $display("FAIL strobe: kind=%0d key=%h at %0d, want kind=%0d key=%h at %0d",
                                     kind, keycode, cyc, e.kind, e.key,
                                     e.cyc);
                        end
                    end
                end
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL timeout: bench did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        int e;
        int g;
        Reset      = 1'b0;
        keycode_in = 8'h00;
        #3;
        chk_idle("reset_state");
        hold(2);
        Reset = 1'b1;
        hold(3);

        // Clean 07 press with three repeats, then release.
        set_key(8'h07, e);
        push(K_PRESS, 8'h07, e + 4);
        push(K_REP, 8'h07, e + 34);
        push(K_REP, 8'h07, e + 42);
        push(K_REP, 8'h07, e + 50);
        hold(3);
        chk_key("pre_press_07", 8'h00);
        hold(1);
        chk_key("press_07", 8'h07);
        hold(47);
        set_key(8'h00, e);
        push(K_REL, 8'h00, e + 4);
        hold(3);
        chk_key("pre_release_07", 8'h07);
        hold(1);
        chk_key("release_07", 8'h00);
        hold(4);

        // Short press and non-movement code: no effect.
        set_key(8'h07, e);
        hold(1);
        set_key(8'h00, e);
        hold(6);
        chk_key("short_07", 8'h00);
        set_key(8'h2C, e);
        hold(9);
        chk_key("code_2c", 8'h00);
        set_key(8'h00, e);
        hold(2);

        // Press 04 then a two-frame glitch to 00.
        set_key(8'h04, e);
        push(K_PRESS, 8'h04, e + 4);
        hold(9);
        chk_key("press_04", 8'h04);
        set_key(8'h00, g);
        hold(1);
        chk_key("glitch_a", 8'h04);
        set_key(8'h04, g);
        chk_key("glitch_b", 8'h04);
        for (int i = 0; i < 8; i++) begin
            hold(1);
            chk_key("glitch_after", 8'h04);
        end

        // Direct switch 04 -> 1A.
        set_key(8'h1A, e);
        push(K_PRESS, 8'h1A, e + 4);
        push(K_REP, 8'h1A, e + 34);
        push(K_REP, 8'h1A, e + 42);
        for (int i = 0; i < 3; i++) begin
            hold(1);
            chk_key("switch_old", 8'h04);
        end
        hold(1);
        chk_key("switch_new", 8'h1A);
        hold(40);

        // Release 1A, press 16, release 16.
        set_key(8'h00, e);
        push(K_REL, 8'h00, e + 4);
        hold(5);
        set_key(8'h16, e);
        push(K_PRESS, 8'h16, e + 4);
        hold(9);
        chk_key("press_16", 8'h16);
        set_key(8'h00, e);
        push(K_REL, 8'h00, e + 4);
        hold(3);
        chk_key("pre_release_16", 8'h16);
        hold(1);
        chk_key("release_16", 8'h00);
        hold(3);

        // Asynchronous reset while 04 is held.
        set_key(8'h04, e);
        push(K_PRESS, 8'h04, e + 4);
        hold(8);
        chk_key("held_pre_reset", 8'h04);
        #2;
        Reset = 1'b0;
        #1;
        chk_idle("async_reset");
        @(negedge frame_clk);
        Reset = 1'b1;
        push(K_PRESS, 8'h04, cyc + 4);
        hold(3);
        chk_key("post_reset_pre", 8'h00);
        hold(1);
        chk_key("post_reset_press", 8'h04);
        set_key(8'h00, e);
        push(K_REL, 8'h00, e + 4);
        hold(8);

        tests++;
        if (sb.size() != 0) begin
            fails++;
            $display("FAIL scoreboard_drain: %0d pending, want 0", sb.size());
        end
        tests++;
        if (rep2_seen != 0) begin
            fails++;
            $display("FAIL norepeat_build: %0d repeat strobes, want 0",
                     rep2_seen);
        end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
